// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the MEM stage.
// A request is accepted over a valid/ready channel, held for WAIT_CYCLES wait
// states, then answered over a valid/ready response channel. Loads are
// sign- or zero-extended by funct3. Stores write only the addressed byte lanes.
// Misaligned, illegal-size and out-of-range accesses return rsp_err=1 and
// rsp_rdata=0, and they do not write storage.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_we                 1 = store, 0 = load
//   req_addr, req_wdata    byte address and right-aligned store data
//   req_funct3             RV32I size code (B/H/W/BU/HU)
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata, rsp_err     extended load data (0 for stores and errors), error flag
//   busy                   a transaction is in flight (hazard-unit stall)
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_f3;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_f3;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [3:0]  w_be;
    logic [31:0] w_sdata;
    logic        w_mem_we;

    assign req_ready = (r_state == S_IDLE) & ~rst;
    assign busy      = (r_state != S_IDLE) & ~rst;
    assign rsp_valid = (r_state == S_RESP) & ~rst;
    assign rsp_rdata = rst ? 32'd0 : r_rdata;
    assign rsp_err   = ~rst & r_err;

    assign w_accept = req_valid & req_ready;

    // With zero wait states the response is formed on the accept edge itself,
    // so the live request is used in IDLE and the captured copy in BUSY.
    assign w_we    = (r_state == S_IDLE) ? req_we     : r_we;
    assign w_addr  = (r_state == S_IDLE) ? req_addr   : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata  : r_wdata;
    assign w_f3    = (r_state == S_IDLE) ? req_funct3 : r_f3;

    assign w_enter_resp = ~rst & (((r_state == S_BUSY) && (r_cnt == 4'd0)) ||
                                  (w_accept && (WAIT_CYCLES == 0)));

    always_comb begin
        w_err = 1'b0;
        case (w_f3)
            3'b011, 3'b110, 3'b111: w_err = 1'b1;
            default: ;
        endcase
        if (w_we && w_f3[2])                               w_err = 1'b1;
        if ((w_f3[1:0] == 2'b01) && w_addr[0])             w_err = 1'b1;
        if ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00)) w_err = 1'b1;
        if ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS))     w_err = 1'b1;
    end

    assign w_idx  = w_addr[AW+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        case (w_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
        case (w_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = w_word;
        endcase
    end

    // The store data is replicated across all lanes, so the byte enables alone
    // select which lanes are written.
    always_comb begin
        case (w_f3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_sdata = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_sdata = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_sdata = w_wdata;
            end
        endcase
    end

    assign w_mem_we = w_enter_resp & w_we & ~w_err;

    // Storage has no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_mem_we && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_sdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_f3    <= req_funct3;
                    if (WAIT_CYCLES == 0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_state <= S_BUSY;
                        r_cnt   <= CNT_INIT;
                    end
                end
                S_BUSY: if (r_cnt == 4'd0) r_state <= S_RESP;
                        else               r_cnt   <= r_cnt - 4'd1;
                S_RESP: if (rsp_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_enter_resp) begin
                r_rdata <= (w_err || w_we) ? 32'd0 : w_load;
                r_err   <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. The main instance uses WAIT_CYCLES=2.
// The second instance uses WAIT_CYCLES=0 and has rsp_ready tied high.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_we = 1'b0;
    logic        z_rsp_ready = 1'b1;
    logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
    logic [2:0]  z_req_funct3 = 3'd0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [31:0] z_rsp_rdata;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_funct3(z_req_funct3), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the WAIT_CYCLES=2 instance, checking latency and result.
    task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        lat = 0;
        while (!req_ready && lat < 50) begin tick(); lat++; end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        tick();
        req_valid = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " ready"}, 32'(req_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // One zero-wait transaction: response the cycle after accept, idle the next.
    task automatic zstep(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd);
        z_req_valid = 1'b1; z_req_we = we; z_req_funct3 = f3;
        z_req_addr = addr; z_req_wdata = wd;
        tick();
        check({tag, " z_valid"}, 32'(z_rsp_valid), 32'd1);
        check({tag, " z_rdata"}, z_rsp_rdata, exp_rd);
        check({tag, " z_err"}, 32'(z_rsp_err), 32'd0);
        tick();
        check({tag, " z_idle"}, {30'd0, z_rsp_valid, z_req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        repeat (2) tick();
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'd0);
        check("rst err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        tick();
        check("idle ready", 32'(req_ready), 32'd1);

        txn("SW10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        txn("LW10", 1'b0, 3'b010, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        txn("SB13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'd0, 1'b0);
        txn("LB13", 1'b0, 3'b000, 32'h13, 32'd0, 32'hFFFFFFA5, 1'b0);
        txn("LBU13", 1'b0, 3'b100, 32'h13, 32'd0, 32'h000000A5, 1'b0);
        txn("LW10b", 1'b0, 3'b010, 32'h10, 32'd0, 32'hA5ADBEEF, 1'b0);
        txn("LH12", 1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFFA5AD, 1'b0);
        txn("LHU12", 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000A5AD, 1'b0);

        txn("LW11", 1'b0, 3'b010, 32'h11, 32'd0, 32'd0, 1'b1);
        txn("SW12", 1'b1, 3'b010, 32'h12, 32'h11111111, 32'd0, 1'b1);
        txn("LH13", 1'b0, 3'b001, 32'h13, 32'd0, 32'd0, 1'b1);
        txn("SBU10", 1'b1, 3'b100, 32'h10, 32'h000000FF, 32'd0, 1'b1);
        txn("LW10c", 1'b0, 3'b010, 32'h10, 32'd0, 32'hA5ADBEEF, 1'b0);
        txn("LW1000", 1'b0, 3'b010, 32'h1000, 32'd0, 32'd0, 1'b1);
        txn("F3_011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1);

        // Backpressure: a second request is already waiting while the first
        // response is held.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        tick();
        req_funct3 = 3'b101;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        check("bp latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp valid", 32'(rsp_valid), 32'd1);
            check("bp rdata", rsp_rdata, 32'hA5ADBEEF);
            check("bp err", 32'(rsp_err), 32'd0);
            check("bp ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp idle", {30'd0, rsp_valid, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("bp 2nd accepted", 32'(busy), 32'd1);
        req_addr = 32'h12; req_funct3 = 3'b010;
        lat = 0;
        while (!rsp_valid && lat < 20) begin tick(); lat++; end
        check("bp2 latency", 32'(lat), 32'd2);
        check("bp2 rdata", rsp_rdata, 32'h0000BEEF);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset while a store is still in its wait states.
        txn("SW20a", 1'b1, 3'b010, 32'h20, 32'd0, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0;
        check("rstmid busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid valid", 32'(rsp_valid), 32'd0);
        check("rstmid busy0", 32'(busy), 32'd0);
        repeat (3) tick();
        check("rstmid no rsp", 32'(rsp_valid), 32'd0);
        txn("LW20", 1'b0, 3'b010, 32'h20, 32'd0, 32'd0, 1'b0);

        // Zero-wait instance: requests arrive back to back, one every two cycles.
        zstep("zSW40", 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'd0);
        zstep("zLW40", 1'b0, 3'b010, 32'h40, 32'd0, 32'hCAFEF00D);
        zstep("zSH42", 1'b1, 3'b001, 32'h42, 32'h00001234, 32'd0);
        zstep("zLW40b", 1'b0, 3'b010, 32'h40, 32'd0, 32'h1234F00D);
        zstep("zLB41", 1'b0, 3'b000, 32'h41, 32'd0, 32'hFFFFFFF0);
        zstep("zLHU42", 1'b0, 3'b101, 32'h42, 32'd0, 32'h00001234);
        z_req_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder that services load/store requests issued by the memory pipeline stage over a valid/ready request channel and a valid/ready response channel. It has a configurable wait-state count, per-size byte-lane writes, and sign/zero-extended loads. It flags misaligned, illegal-size and out-of-range accesses. It holds a single outstanding transaction and exposes busy so the hazard unit can stall the pipeline.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in storage; word index = addr[31:2].
WAIT_CYCLES, 2, wait states between accept and response; legal range 0..15.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
req_funct3  input  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  output  1  response present
rsp_ready  input  1  requester consumes response
rsp_rdata  output  32  load result, extended; 0 for stores and errors
rsp_err  output  1  access rejected
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, BUSY, RESP. A wait counter cnt is 4 bits wide.
- Reset: state=IDLE, cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst is high. Storage contents are not cleared. Reset takes priority over every other event on the same edge.
- req_ready = (state==IDLE) & ~rst.
- Accept occurs at an edge with req_valid & req_ready. On accept, capture we/addr/wdata/funct3.
  - If WAIT_CYCLES==0: go to RESP.
  - Otherwise: go to BUSY with cnt = WAIT_CYCLES-1.
- BUSY: if cnt==0, go to RESP; else decrement cnt. BUSY lasts exactly WAIT_CYCLES cycles.
- Entry into RESP: the store commits to storage and rsp_rdata/rsp_err are registered on this same edge. Accepted at edge k, rsp_valid is first high after edge k+WAIT_CYCLES.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until an edge with rsp_ready=1.
  - On that edge, go to IDLE and clear rsp_valid.
  - No new request is accepted in the same cycle; minimum spacing is WAIT_CYCLES+2 cycles per transaction.
- Error conditions force rsp_err=1, rsp_rdata=0, no storage write, full normal latency:
  - funct3 is 011, 110 or 111.
  - Store with funct3 100 or 101.
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - addr[31:2] >= DEPTH_WORDS.
- Store lanes are little-endian:
  - SB writes byte addr[1:0] with wdata[7:0].
  - SH writes halfword addr[1] with wdata[15:0].
  - SW writes all four bytes.
  - Other bytes are untouched.
- Load extraction uses the same lane selection:
  - LB/LH sign-extend to 32 bits.
  - LBU/LHU zero-extend.
  - LW returns the full word.
- Reset while in BUSY: the transaction is dropped and a pending store never commits. Reset in RESP: the response is discarded.
- req_valid changes while not in IDLE are ignored; the captured request is not affected.

Test Plan:
- WAIT_CYCLES=2; SW 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid first high 2 edges after accept; req_ready=0 and busy=1 from accept until response consumed.
- SB 0x13 data 0x000000A5, then:
  - LB 0x13 -> 0xFFFFFFA5
  - LBU 0x13 -> 0x000000A5
  - LW 0x10 -> 0xA5ADBEEF
  - LH 0x12 -> 0xFFFFA5AD
  - LHU 0x12 -> 0x0000A5AD
- Error cases:
  - LW 0x11 -> rsp_err=1, rsp_rdata=0.
  - SW 0x12 data 0x11111111 -> rsp_err=1; LW 0x10 still returns 0xA5ADBEEF.
  - LW 0x1000 (DEPTH 1024) -> rsp_err=1.
  - funct3=011 -> rsp_err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles during an LW 0x10 response -> rsp_valid, rsp_rdata=0xA5ADBEEF and rsp_err stay constant, and req_ready stays 0. A second req_valid in that window is not accepted; it is accepted only after IDLE returns.
- Reset mid-operation: SW 0x20 data 0 completed; SW 0x20 data 0x12345678 accepted; rst pulsed 1 cycle while in BUSY -> rsp_valid=0, busy=0 next cycle; a subsequent LW 0x20 returns 0x00000000.
- WAIT_CYCLES=0 build: back-to-back SW/LW with rsp_ready tied high -> rsp_valid high the cycle after accept, one transaction every 2 cycles, correct data.
